// File: rtl/in_port_ctrl.sv
// Receive-side input port for the 8-bit CPU: an external valid/ready producer fills a small FIFO,
// the CPU's IN instruction pops it, and an occupancy threshold drives the interrupt request.
module in_port_ctrl #(
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   ext_data,
    input  logic                         ext_valid,
    output logic                         ext_ready,
    input  logic                         in_rd,
    output logic [7:0]                   in_data,
    output logic                         in_empty,
    input  logic                         int_en,
    input  logic                         int_ack,
    output logic                         int_sig,
    output logic                         underflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] IRQ_LVL  = CW'(IRQ_LEVEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } irq_state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_in_data;
    logic          r_underflow;
    logic          r_int_sig;
    irq_state_t    r_state;

    logic          w_push;
    logic          w_pop;
    logic          w_empty_rd;
    logic [CW-1:0] w_count_next;

    // Flow control decodes registered occupancy only, so ext_ready never depends on ext_valid.
    assign ext_ready    = (r_count != FULL_LVL);
    assign in_empty     = (r_count == '0);
    assign w_push       = ext_valid && ext_ready;
    assign w_pop        = in_rd && !in_empty;
    assign w_empty_rd   = in_rd && in_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    assign in_data   = r_in_data;
    assign underflow = r_underflow;
    assign int_sig   = r_int_sig;
    assign count     = r_count;

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= ext_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_data   <= 8'h00;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_in_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end
            if (w_empty_rd) begin
                r_underflow <= 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Interrupt FSM; DRAIN blocks re-requests until the ISR pulls occupancy below the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_int_sig <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (int_en && (w_count_next >= IRQ_LVL)) begin
                        r_state   <= PEND;
                        r_int_sig <= 1'b1;
                    end
                end
                PEND: begin
                    if (int_ack) begin
                        r_state   <= DRAIN;
                        r_int_sig <= 1'b0;
                    end else if (!int_en) begin
                        r_state   <= IDLE;
                        r_int_sig <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_count_next < IRQ_LVL) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_int_sig <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl (DEPTH=4, IRQ_LEVEL=1) with hand-computed expected values.
module tb_in_port_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       in_rd;
    logic [7:0] in_data;
    logic       in_empty;
    logic       int_en;
    logic       int_ack;
    logic       int_sig;
    logic       underflow;
    logic [2:0] count;

    int n_vec = 0;
    int n_err = 0;

    in_port_ctrl #(.DEPTH(4), .IRQ_LEVEL(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .int_en    (int_en),
        .int_ack   (int_ack),
        .int_sig   (int_sig),
        .underflow (underflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ext_data = 8'h00; ext_valid = 1'b0; in_rd = 1'b0;
        int_en = 1'b0; int_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", ext_ready, 1);
        check("rst_empty", in_empty, 1);
        check("rst_data", in_data, 8'h00);
        check("rst_int", int_sig, 0);
        check("rst_uf", underflow, 0);
        check("rst_count", count, 0);

        // single push then pop
        ext_data = 8'h55; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        check("t1_count1", count, 1);
        check("t1_empty0", in_empty, 0);
        step();
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t1_data", in_data, 8'h55);
        check("t1_count0", count, 0);
        check("t1_int", int_sig, 0);

        // streaming fill to full, back-pressure, refill after one pop
        ext_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_data = 8'h10 + 8'(i);
            step();
        end
        check("t2_full_cnt", count, 4);
        check("t2_ready0", ext_ready, 0);
        ext_data = 8'h14; step();
        check("t2_held_cnt", count, 4);
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t2_pop0", in_data, 8'h10);
        check("t2_cnt3", count, 3);
        check("t2_ready1", ext_ready, 1);
        step(); ext_valid = 1'b0;
        check("t2_refill", count, 4);
        in_rd = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t2_pop%0d", i), in_data, 8'h10 + 8'(i));
        end
        in_rd = 1'b0;
        check("t2_drained", count, 0);

        // empty read
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t3_hold", in_data, 8'h14);
        check("t3_uf", underflow, 1);
        check("t3_cnt", count, 0);
        ext_data = 8'hA7; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t3_data", in_data, 8'hA7);
        check("t3_uf_sticky", underflow, 1);

        // simultaneous push/pop across pointer wrap
        ext_valid = 1'b1;
        ext_data = 8'h20; step();
        ext_data = 8'h21; step();
        check("t4_cnt2", count, 2);
        in_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ext_data = 8'h22 + 8'(i);
            step();
            check($sformatf("t4_data%0d", i), in_data, 8'h20 + 8'(i));
            check($sformatf("t4_cnt%0d", i), count, 2);
        end
        ext_valid = 1'b0;
        step(); check("t4_tail0", in_data, 8'h28);
        step(); check("t4_tail1", in_data, 8'h29);
        in_rd = 1'b0;
        check("t4_empty", in_empty, 1);

        // interrupt request / ack / drain / re-arm
        int_en = 1'b1;
        ext_data = 8'h3C; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        check("t5_irq", int_sig, 1);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        check("t5_ack", int_sig, 0);
        ext_data = 8'h3D; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        check("t5_no_rearm", int_sig, 0);
        check("t5_cnt2", count, 2);
        in_rd = 1'b1; step();
        check("t5_pop0", in_data, 8'h3C);
        step(); in_rd = 1'b0;
        check("t5_pop1", in_data, 8'h3D);
        check("t5_idle", int_sig, 0);
        ext_data = 8'h3E; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        check("t5_rearm", int_sig, 1);
        int_en = 1'b0; step();
        check("t5_en_drop", int_sig, 0);
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t5_pop2", in_data, 8'h3E);

        // reset in the middle of traffic
        int_en = 1'b1; ext_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_data = 8'h61 + 8'(i);
            step();
        end
        check("t6_pre_cnt", count, 3);
        check("t6_pre_irq", int_sig, 1);
        rst = 1'b1; in_rd = 1'b1; step();
        rst = 1'b0; in_rd = 1'b0; ext_valid = 1'b0; int_en = 1'b0;
        check("t6_cnt", count, 0);
        check("t6_empty", in_empty, 1);
        check("t6_data", in_data, 8'h00);
        check("t6_int", int_sig, 0);
        check("t6_uf", underflow, 0);
        check("t6_ready", ext_ready, 1);
        int_en = 1'b1; step();
        check("t6_idle", int_sig, 0);
        ext_data = 8'h70; ext_valid = 1'b1; step(); ext_valid = 1'b0;
        check("t6_irq", int_sig, 1);
        in_rd = 1'b1; step(); in_rd = 1'b0;
        check("t6_pop", in_data, 8'h70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
